uart_rx_fsm: RTL and testbench

- Receive-side sequencer for the UART RX path.
- Detects the start edge on RX_IN, enables and steers the edge/bit counter, and gates the data sampler, deserializer and start/parity/stop checkers frame by frame.
- Issues a one-cycle data_valid for each error-free frame and holds registered error flags for the last frame.
- Sits between the RX pin synchronizer and the RX datapath blocks inside the UART RX top.

---
 rtl/uart_rx_fsm.sv | 115 +++++++++++
 tb/tb_uart_rx_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: finds the start edge, runs the edge/bit counter and
// strobes the sampler, deserializer and start/parity/stop checkers once per bit.
module uart_rx_fsm #(
  parameter int DATA_WIDTH        = 8,
  parameter int BIT_COUNTER_WIDTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         RX_IN,
  input  logic                         PAR_EN,
  input  logic [4:0]                   Prescale,
  input  logic [BIT_COUNTER_WIDTH-1:0] bit_cnt,
  input  logic [4:0]                   edge_cnt,
  input  logic                         strt_glitch,
  input  logic                         par_err,
  input  logic                         stp_err,
  output logic                         edge_cnt_en,
  output logic                         start_trans,
  output logic                         dat_samp_en,
  output logic                         deser_en,
  output logic                         strt_chk_en,
  output logic                         par_chk_en,
  output logic                         stp_chk_en,
  output logic                         data_valid,
  output logic                         par_error,
  output logic                         stop_error,
  output logic                         busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  localparam logic [BIT_COUNTER_WIDTH-1:0] FIRST_DATA_BIT = BIT_COUNTER_WIDTH'(1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] PARITY_BIT     = BIT_COUNTER_WIDTH'(DATA_WIDTH + 1);
  localparam logic [BIT_COUNTER_WIDTH-1:0] STOP_AFTER_PAR = BIT_COUNTER_WIDTH'(DATA_WIDTH + 2);

  state_t     state, state_nx;
  logic       par_en_r;
  logic [4:0] chk_edge;
  logic       chk;

  // One edge past the 3-sample majority window centred on mid-bit.
  assign chk_edge = (Prescale >> 1) + 5'd2;
  assign chk      = (edge_cnt == chk_edge);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Flags live from one start detection to the next so software can read them after DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_r   <= 1'b0;
      par_error  <= 1'b0;
      stop_error <= 1'b0;
    end else begin
      if (state == IDLE && !RX_IN) begin
        par_en_r   <= PAR_EN;
        par_error  <= 1'b0;
        stop_error <= 1'b0;
      end
      if (par_chk_en) par_error  <= par_err;
      if (stp_chk_en) stop_error <= stp_err;
    end
  end

  always_comb begin
    state_nx    = state;
    edge_cnt_en = 1'b0;
    start_trans = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) state_nx = START;
      end
      START: begin
        edge_cnt_en = 1'b1;
        start_trans = 1'b1;
        strt_chk_en = chk;
        if (chk && strt_glitch)          state_nx = IDLE;
        else if (bit_cnt == FIRST_DATA_BIT) state_nx = DATA;
      end
      DATA: begin
        edge_cnt_en = 1'b1;
        deser_en    = chk;
        if (bit_cnt == PARITY_BIT) state_nx = par_en_r ? PARITY : STOP;
      end
      PARITY: begin
        edge_cnt_en = 1'b1;
        par_chk_en  = chk;
        if (bit_cnt == STOP_AFTER_PAR) state_nx = STOP;
      end
      STOP: begin
        // Leave at the stop check rather than the end of the bit so a
        // back-to-back start edge is not missed.
        edge_cnt_en = 1'b1;
        stp_chk_en  = chk;
        if (chk) state_nx = DONE;
      end
      DONE: begin
        data_valid = !par_error && !stop_error;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dat_samp_en = edge_cnt_en;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: serial line driver, edge/bit counter and line-based
// checkers around the DUT, with frame-level expectations from a simple model.
module tb_uart_rx_fsm;
  localparam int DW  = 8;
  localparam int BCW = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic           RX_IN;
  logic           PAR_EN;
  logic [4:0]     Prescale;
  logic [BCW-1:0] bit_cnt;
  logic [4:0]     edge_cnt;
  logic           strt_glitch, par_err, stp_err;
  logic           edge_cnt_en, start_trans, dat_samp_en, deser_en;
  logic           strt_chk_en, par_chk_en, stp_chk_en, data_valid;
  logic           par_error, stop_error, busy;

  uart_rx_fsm #(.DATA_WIDTH(DW), .BIT_COUNTER_WIDTH(BCW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .edge_cnt_en(edge_cnt_en),
    .start_trans(start_trans), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .par_error(par_error), .stop_error(stop_error),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         p;
    bit         pe;
    logic [7:0] d;
    bit         bad_par;
    bit         stop_b;
    bit         glitch;
    int         gap;
    bit         exp_dv;
    bit         exp_perr;
    bit         exp_serr;
  } vec_t;

  int         n_cmp = 0, n_fail = 0;
  int         dv_cnt = 0, deser_cnt = 0, par_cnt = 0, stp_cnt = 0, strt_cnt = 0, place_bad = 0;
  logic [7:0] cur_d = 8'h00;
  logic [7:0] shreg = 8'h00;
  bit         cur_pe = 1'b0;
  bit         noise = 1'b0;

  // Neighbouring blocks: edge/bit counter and checkers that read the line directly.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!edge_cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (int'(edge_cnt) == (start_trans ? int'(Prescale) - 2 : int'(Prescale) - 1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign strt_glitch = strt_chk_en ? RX_IN : noise;
  assign par_err     = par_chk_en ? (RX_IN != ^cur_d) : noise;
  assign stp_err     = stp_chk_en ? !RX_IN : ~noise;

  // Strobe placement monitor: each strobe only on the check edge of its own bit.
  always @(negedge CLK) begin
    int bad;
    bad = 0;
    noise <= 1'($urandom);
    if (dat_samp_en !== edge_cnt_en) bad++;
    if ($countones({strt_chk_en, deser_en, par_chk_en, stp_chk_en}) > 1) bad++;
    if ((strt_chk_en | deser_en | par_chk_en | stp_chk_en) &&
        int'(edge_cnt) != int'(Prescale) / 2 + 2) bad++;
    if (strt_chk_en) begin
      strt_cnt <= strt_cnt + 1;
      if (int'(bit_cnt) != 0) bad++;
    end
    if (deser_en) begin
      deser_cnt <= deser_cnt + 1;
      shreg     <= {RX_IN, shreg[7:1]};
      if (int'(bit_cnt) < 1 || int'(bit_cnt) > DW) bad++;
    end
    if (par_chk_en) begin
      par_cnt <= par_cnt + 1;
      if (!cur_pe || int'(bit_cnt) != DW + 1) bad++;
    end
    if (stp_chk_en) begin
      stp_cnt <= stp_cnt + 1;
      if (int'(bit_cnt) != DW + 1 + int'(cur_pe)) bad++;
    end
    if (data_valid) dv_cnt <= dv_cnt + 1;
    place_bad <= place_bad + bad;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_dv   = !v.glitch && v.stop_b && !(v.pe && v.bad_par);
    r.exp_perr = !v.glitch && v.pe && v.bad_par;
    r.exp_serr = !v.glitch && !v.stop_b;
    return r;
  endfunction

  // Drives one frame from a negedge; line bits last Prescale cycles each.
  task automatic send_frame(input vec_t v);
    int c  = v.p / 2 + 2;
    int d0 = dv_cnt, s0 = deser_cnt, p0 = par_cnt, t0 = stp_cnt, g0 = strt_cnt, b0 = place_bad;
    Prescale = 5'(v.p);
    PAR_EN   = v.pe;
    cur_pe   = v.pe;
    cur_d    = v.d;
    RX_IN    = 1'b0;
    @(negedge CLK);
    check("start_busy", busy, 1);
    check("start_trans", start_trans, 1);
    check("flags_cleared", {par_error, stop_error}, 0);
    PAR_EN = 1'($urandom);
    if (v.glitch) begin
      @(negedge CLK);
      RX_IN = 1'b1;
      repeat (2 * v.p) @(negedge CLK);
    end else begin
      repeat (v.p - 1) @(negedge CLK);
      for (int i = 0; i < DW; i++) begin
        RX_IN = v.d[i];
        repeat (v.p) @(negedge CLK);
      end
      if (v.pe) begin
        RX_IN = (^v.d) ^ v.bad_par;
        repeat (v.p) @(negedge CLK);
      end
      RX_IN = v.stop_b;
      repeat (c + 1) @(negedge CLK);
      check("done_valid", data_valid, v.exp_dv);
      check("done_par_error", par_error, v.exp_perr);
      check("done_stop_error", stop_error, v.exp_serr);
      if (v.exp_dv) check("data_word", shreg, v.d);
      repeat (v.p - c - 1) @(negedge CLK);
    end
    check("end_busy", busy, 0);
    check("end_valid", data_valid, 0);
    check("valid_pulses", dv_cnt - d0, v.exp_dv);
    check("deser_pulses", deser_cnt - s0, v.glitch ? 0 : DW);
    check("par_chk_pulses", par_cnt - p0, (!v.glitch && v.pe) ? 1 : 0);
    check("stp_chk_pulses", stp_cnt - t0, v.glitch ? 0 : 1);
    check("strt_chk_pulses", strt_cnt - g0, 1);
    check("strobe_place", place_bad - b0, 0);
    check("end_par_error", par_error, v.exp_perr);
    check("end_stop_error", stop_error, v.exp_serr);
    if (v.gap > 0) begin
      RX_IN = 1'b1;
      repeat (v.gap * v.p) @(negedge CLK);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    int   d0;
    //              p  pe  d      bad stp gl gap dv pe se
    tbl[0] = '{ 8, 1, 8'hA5, 0, 1, 0, 1, 1, 0, 0};
    tbl[1] = '{16, 0, 8'h3C, 0, 1, 0, 1, 1, 0, 0};
    tbl[2] = '{ 8, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0};
    tbl[3] = '{ 8, 1, 8'h55, 1, 1, 0, 1, 0, 1, 0};
    tbl[4] = '{ 8, 0, 8'hC3, 0, 0, 0, 0, 0, 0, 1};
    tbl[5] = '{ 8, 1, 8'h5A, 0, 1, 0, 0, 1, 0, 0};
    tbl[6] = '{ 8, 1, 8'h00, 1, 0, 0, 1, 0, 1, 1};
    tbl[7] = '{16, 1, 8'h81, 1, 1, 0, 0, 0, 1, 0};
    tbl[8] = '{16, 1, 8'hFF, 0, 1, 0, 1, 1, 0, 0};

    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 5'd8;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {edge_cnt_en, start_trans, dat_samp_en, deser_en, strt_chk_en,
          par_chk_en, stp_chk_en, data_valid, par_error, stop_error, busy}, 0);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("idle_busy", busy, 0);

    foreach (tbl[i]) send_frame(tbl[i]);
    RX_IN = 1'b1;
    repeat (16) @(negedge CLK);

    // Reset in the middle of data bit 4.
    v = model('{8, 1, 8'h96, 0, 1, 0, 1, 0, 0, 0});
    Prescale = 5'd8; PAR_EN = 1'b1; cur_pe = 1'b1; cur_d = v.d;
    d0 = dv_cnt;
    RX_IN = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      RX_IN = v.d[i];
      repeat (8) @(negedge CLK);
    end
    RX_IN = v.d[3];
    repeat (2) @(negedge CLK);
    check("pre_reset_busy", busy, 1);
    RST = 1'b0;
    #1;
    check("midframe_reset_outputs", {edge_cnt_en, start_trans, dat_samp_en, deser_en, strt_chk_en,
          par_chk_en, stp_chk_en, data_valid, par_error, stop_error, busy}, 0);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("reset_no_valid", dv_cnt - d0, 0);
    send_frame(v);

    // Randomized frames against the model.
    for (int n = 0; n < 24; n++) begin
      v.p       = ($urandom_range(0, 1) == 1) ? 16 : 8;
      v.pe      = 1'($urandom);
      v.d       = 8'($urandom);
      v.bad_par = v.pe && ($urandom_range(0, 3) == 0);
      v.stop_b  = !(v.p == 8 && $urandom_range(0, 3) == 0);
      v.glitch  = ($urandom_range(0, 9) == 0);
      v.gap     = $urandom_range(0, 2);
      send_frame(model(v));
    end
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
